countdown_loadable: RTL and testbench
=====================================

Name: countdown_loadable

Overview:
- Loadable N-bit down counter with prescaler, pause and a one-cycle done pulse.
- Counterpart to the free-running up counter: counts from a loaded value down to zero.
- Used as a countdown/timeout source for lab FSMs and display timers.
- Output `counter` can drive the same 7-seg/LED paths as the up counter.

Parameters:
- N, 8, counter and load width in bits (N >= 2).
- PRESCALE, 1, enabled clock cycles per decrement (>= 1); prescaler width is $clog2(PRESCALE), minimum 1 bit.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- abort  input  1  synchronous cancel; return to IDLE, counter cleared.
- load  input  1  synchronous load strobe.
- load_value  input  N  value captured on load.
- enable  input  1  count enable; low pauses prescaler and counter.
- counter  output  N  current count.
- busy  output  1  high while state is RUN.
- zero  output  1  high when counter == 0 (combinational from counter register).
- done  output  1  one-cycle pulse when the count reaches 0 by decrementing.

Behaviour:
- Reset (reset == 0, asynchronous): state = IDLE, counter = 0, prescaler = 0, busy = 0, done = 0, zero = 1.
- State machine has two states.
  - IDLE: counter holds its value; enable is ignored.
  - RUN: counting.
- Priority at each rising edge: abort > load > count.
- abort:
  - state <= IDLE, counter <= 0, prescaler <= 0, done = 0.
  - Valid in any state.
- load, any state:
  - counter <= load_value and prescaler <= 0.
  - load_value != 0: state <= RUN.
  - load_value == 0: state <= IDLE, no done pulse.
  - A load while in RUN restarts the count; no done pulse is produced.
- Count (RUN, enable == 1, no abort/load):
  - If prescaler == PRESCALE-1: prescaler <= 0 and counter <= counter - 1. Otherwise prescaler <= prescaler + 1.
- Terminal condition:
  - The decrement that takes counter from 1 to 0 sets done = 1 for exactly the next cycle, coincident with counter == 0 becoming visible.
  - State then goes to IDLE; see the optional feature for the alternative.
- Pause: enable == 0 in RUN freezes both counter and prescaler; busy stays 1.
- Latency:
  - load_value appears on counter 1 cycle after the load edge.
  - With enable held high, the first decrement is visible PRESCALE cycles after that.
  - A count of V takes V*PRESCALE enabled cycles from load to done.
- done is registered and never asserted in IDLE except on the cycle immediately following the terminal decrement.
- No underflow: counter never decrements below 0; N-bit wrap from 0 to 2^N-1 is impossible by construction.
- reset asserted mid-count: immediate return to reset values; no done pulse.
- load and abort in the same cycle: abort wins; load_value is discarded.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - An N-bit reload register captures load_value on every accepted load; reset value is 0.
  - On the terminal decrement, done pulses as normal.
  - counter <= reload register instead of 0, prescaler <= 0, and state stays RUN.
  - counter is never observed at 0 in this case, so zero stays 0.
  - Periodic done pulses every V*PRESCALE enabled cycles.
  - abort clears the counter but preserves the reload register.
- Not defined:
  - No reload register.
  - The terminal decrement leaves counter = 0, state = IDLE, busy = 0, zero = 1.

Test Plan:
- Reset, then load_value = 8'd5 with enable = 1 and PRESCALE = 1 → counter sequence is 5,4,3,2,1,0 on consecutive cycles.
  - done = 1 only in the cycle counter first equals 0.
  - busy falls in that same cycle; zero = 1 thereafter.
- PRESCALE = 4, load 3 → each value holds 4 cycles; done arrives 12 cycles after counter first shows 3.
- load 6, drop enable for 10 cycles when counter = 4 → counter holds 4 and busy = 1 throughout; counting resumes to 0 with exactly one done pulse.
- load 9, then at counter = 2 assert load with load_value = 7 → counter becomes 7, no done pulse; at counter = 3 assert abort together with load → counter = 0, IDLE, no done.
- Drive reset low while counter = 3 (asynchronous, mid-cycle) → outputs go to reset values before the next edge; load with load_value = 0 → stays IDLE, done never pulses.
- COUNTDOWN_AUTO_RELOAD_EN defined, load 2 with PRESCALE = 1 → counter sequence 2,1,2,1,...; done pulses every 2 cycles and zero stays 0; abort → counter = 0, IDLE.

Source files
------------

// File: rtl/countdown_loadable.sv
// Loadable N-bit down counter with prescaler, pause and a one-cycle done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded value instead of stopping at zero.
module countdown_loadable #(
  parameter int N        = 8,
  parameter int PRESCALE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         abort,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         enable,
  output logic [N-1:0] counter,
  output logic         busy,
  output logic         zero,
  output logic         done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  counter_q, counter_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic [N-1:0]  reload_val;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [N-1:0] reload_q, reload_d;

  // Reload register survives abort; only reset clears it.
  always_comb begin
    reload_d = reload_q;
    if (!abort && load) reload_d = load_value;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) reload_q <= '0;
    else        reload_q <= reload_d;
  end

  assign reload_val = reload_q;
`else
  assign reload_val = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
    end
  end

  // Priority: abort > load > count. done_d defaults low so done is a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    presc_d   = presc_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      counter_d = '0;
      presc_d   = '0;
    end else if (load) begin
      counter_d = load_value;
      presc_d   = '0;
      state_d   = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN && enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (counter_q <= N'(1)) begin
          done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          counter_d = reload_val;
          state_d   = ST_RUN;
`else
          counter_d = '0;
          state_d   = ST_IDLE;
`endif
        end else begin
          counter_d = counter_q - N'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    counter = counter_q;
    busy    = (state_q == ST_RUN);
    zero    = (counter_q == '0);
    done    = done_q;
  end

  // Only consulted in the auto-reload build.
  logic unused_reload;
  assign unused_reload = ^reload_val;

endmodule

// File: tb/tb_countdown_loadable.sv
// Directed bench for countdown_loadable: a PRESCALE=1 instance and a PRESCALE=4 instance share stimulus.
module tb_countdown_loadable;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         abort;
  logic         load;
  logic [N-1:0] load_value;
  logic         enable;

  logic [N-1:0] cnt1, cnt4;
  logic         busy1, busy4, zero1, zero4, done1, done4;

  int tests_run = 0;
  int tests_failed = 0;

  countdown_loadable #(.N(N), .PRESCALE(1)) dut1 (
    .clock(clk), .reset(rst_n), .abort(abort), .load(load), .load_value(load_value),
    .enable(enable), .counter(cnt1), .busy(busy1), .zero(zero1), .done(done1)
  );

  countdown_loadable #(.N(N), .PRESCALE(4)) dut4 (
    .clock(clk), .reset(rst_n), .abort(abort), .load(load), .load_value(load_value),
    .enable(enable), .counter(cnt4), .busy(busy4), .zero(zero4), .done(done4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [N-1:0] v);
    load = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (cnt1 !== 8'd0 || busy1 !== 1'b0 || zero1 !== 1'b1 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_p1: cnt=%0d busy=%b zero=%b done=%b, want 0 0 1 0", cnt1, busy1, zero1, done1);
    end
    tests_run++;
    if (cnt4 !== 8'd0 || busy4 !== 1'b0 || zero4 !== 1'b1 || done4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_p4: cnt=%0d busy=%b zero=%b done=%b, want 0 0 1 0", cnt4, busy4, zero4, done4);
    end
  endtask

  task automatic test_basic_count();
    logic [N-1:0] exp_c;
    enable = 1'b1;
    do_load(8'd5);
    tests_run++;
    if (cnt1 !== 8'd5 || busy1 !== 1'b1 || zero1 !== 1'b0 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_load: cnt=%0d busy=%b zero=%b done=%b, want 5 1 0 0", cnt1, busy1, zero1, done1);
    end
    for (int k = 4; k >= 0; k--) begin
      tick();
      exp_c = N'(k);
      tests_run++;
      if (cnt1 !== exp_c || done1 !== (k == 0) || busy1 !== (k != 0) || zero1 !== (k == 0)) begin
        tests_failed++;
        $display("FAIL basic_seq: cnt=%0d done=%b busy=%b zero=%b, want cnt=%0d done=%b busy=%b zero=%b",
                 cnt1, done1, busy1, zero1, exp_c, (k == 0), (k != 0), (k == 0));
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (cnt1 !== 8'd0 || done1 !== 1'b0 || busy1 !== 1'b0 || zero1 !== 1'b1) begin
        tests_failed++;
        $display("FAIL basic_after: cnt=%0d done=%b busy=%b zero=%b, want 0 0 0 1", cnt1, done1, busy1, zero1);
      end
    end
  endtask

  task automatic test_prescale();
    logic [N-1:0] exp_c;
    enable = 1'b1;
    do_load(8'd3);
    tests_run++;
    if (cnt4 !== 8'd3 || busy4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL presc_load: cnt=%0d busy=%b, want 3 1", cnt4, busy4);
    end
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_c = (k >= 12) ? 8'd0 : N'(3 - k / 4);
      tests_run++;
      if (cnt4 !== exp_c || done4 !== (k == 12) || busy4 !== (k < 12)) begin
        tests_failed++;
        $display("FAIL presc_seq[%0d]: cnt=%0d done=%b busy=%b, want cnt=%0d done=%b busy=%b",
                 k, cnt4, done4, busy4, exp_c, (k == 12), (k < 12));
      end
    end
  endtask

  task automatic test_pause();
    int done_cnt;
    enable = 1'b1;
    do_load(8'd6);
    tick(); tick();
    tests_run++;
    if (cnt1 !== 8'd4) begin
      tests_failed++;
      $display("FAIL pause_pre: cnt=%0d, want 4", cnt1);
    end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++;
      if (cnt1 !== 8'd4 || busy1 !== 1'b1 || done1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL pause_hold[%0d]: cnt=%0d busy=%b done=%b, want 4 1 0", k, cnt1, busy1, done1);
      end
    end
    enable = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done1) done_cnt++;
    end
    tests_run++;
    if (done_cnt != 1 || cnt1 !== 8'd0 || busy1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_resume: done_pulses=%0d cnt=%0d busy=%b, want 1 0 0", done_cnt, cnt1, busy1);
    end
  endtask

  task automatic test_load_restart_abort();
    enable = 1'b1;
    do_load(8'd9);
    for (int k = 0; k < 7; k++) tick();
    tests_run++;
    if (cnt1 !== 8'd2) begin
      tests_failed++;
      $display("FAIL restart_pre: cnt=%0d, want 2", cnt1);
    end
    do_load(8'd7);
    tests_run++;
    if (cnt1 !== 8'd7 || done1 !== 1'b0 || busy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_load: cnt=%0d done=%b busy=%b, want 7 0 1", cnt1, done1, busy1);
    end
    for (int k = 0; k < 4; k++) tick();
    tests_run++;
    if (cnt1 !== 8'd3) begin
      tests_failed++;
      $display("FAIL abort_pre: cnt=%0d, want 3", cnt1);
    end
    abort = 1'b1;
    load = 1'b1;
    load_value = 8'd7;
    tick();
    abort = 1'b0;
    load = 1'b0;
    tests_run++;
    if (cnt1 !== 8'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || zero1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_with_load: cnt=%0d busy=%b done=%b zero=%b, want 0 0 0 1", cnt1, busy1, done1, zero1);
    end
    tick(); tick();
    tests_run++;
    if (cnt1 !== 8'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: cnt=%0d busy=%b done=%b, want 0 0 0", cnt1, busy1, done1);
    end
  endtask

  task automatic test_boundaries();
    enable = 1'b1;
    do_load(8'd255);
    tests_run++;
    if (cnt1 !== 8'd255 || busy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL max_load: cnt=%0d busy=%b, want 255 1", cnt1, busy1);
    end
    tick();
    tests_run++;
    if (cnt1 !== 8'd254) begin
      tests_failed++;
      $display("FAIL max_dec: cnt=%0d, want 254", cnt1);
    end
    do_load(8'd1);
    tests_run++;
    if (cnt1 !== 8'd1 || busy1 !== 1'b1 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL one_load: cnt=%0d busy=%b done=%b, want 1 1 0", cnt1, busy1, done1);
    end
    tick();
    tests_run++;
    if (cnt1 !== 8'd0 || done1 !== 1'b1 || busy1 !== 1'b0 || zero1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL one_done: cnt=%0d done=%b busy=%b zero=%b, want 0 1 0 1", cnt1, done1, busy1, zero1);
    end
    // Load while idle with enable low: counter takes the value but must not move.
    enable = 1'b0;
    do_load(8'd3);
    tick(); tick();
    tests_run++;
    if (cnt1 !== 8'd3 || busy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_paused: cnt=%0d busy=%b, want 3 1", cnt1, busy1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    do_load(8'd5);
    tick(); tick();
    tests_run++;
    if (cnt1 !== 8'd3) begin
      tests_failed++;
      $display("FAIL rst_pre: cnt=%0d, want 3", cnt1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (cnt1 !== 8'd0 || busy1 !== 1'b0 || zero1 !== 1'b1 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: cnt=%0d busy=%b zero=%b done=%b, want 0 0 1 0", cnt1, busy1, zero1, done1);
    end
    tick();
    rst_n = 1'b1;
    do_load(8'd0);
    tests_run++;
    if (cnt1 !== 8'd0 || busy1 !== 1'b0 || zero1 !== 1'b1 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_zero: cnt=%0d busy=%b zero=%b done=%b, want 0 0 1 0", cnt1, busy1, zero1, done1);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL load_zero_idle[%0d]: done=%b busy=%b, want 0 0", k, done1, busy1);
      end
    end
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [N-1:0] exp_c;
    enable = 1'b1;
    do_load(8'd2);
    tests_run++;
    if (cnt1 !== 8'd2 || busy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_load: cnt=%0d busy=%b, want 2 1", cnt1, busy1);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_c = (k % 2 == 1) ? 8'd1 : 8'd2;
      tests_run++;
      if (cnt1 !== exp_c || done1 !== (k % 2 == 0) || zero1 !== 1'b0 || busy1 !== 1'b1) begin
        tests_failed++;
        $display("FAIL reload_seq[%0d]: cnt=%0d done=%b zero=%b busy=%b, want cnt=%0d done=%b zero=0 busy=1",
                 k, cnt1, done1, zero1, busy1, exp_c, (k % 2 == 0));
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (cnt1 !== 8'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_abort: cnt=%0d busy=%b done=%b, want 0 0 0", cnt1, busy1, done1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_count();
    test_prescale();
    test_pause();
    test_load_restart_abort();
    test_boundaries();
    test_async_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so a stuck run still ends with a summary.
  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: simulation time limit reached, want completion before 200000");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
